prio_encoder_arb: RTL and testbench

PRIO_ENCODER_ARB -- requirements
Module: prio_encoder_arb

---
 rtl/prio_encoder_arb_if.sv | 25 ++
 rtl/prio_encoder_arb.sv | 101 ++++++++++
 tb/tb_prio_encoder_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle for the priority-encoder arbiter.
// The slave side is the arbiter; the master side drives requests and acks.
interface prio_encoder_arb_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
);
  logic         en_in_n;
  logic [N-1:0] v_n;
  logic         rr_mode;
  logic         ack;
  logic [W-1:0] y;
  logic         valid;
  logic         gs;
  logic         en_out;

  modport slave (
    input  en_in_n, v_n, rr_mode, ack,
    output y, valid, gs, en_out
  );

  modport master (
    output en_in_n, v_n, rr_mode, ack,
    input  y, valid, gs, en_out
  );
endinterface

// File: rtl/prio_encoder_arb.sv
// Sticky-request priority encoder with a fixed / round-robin arbiter and a
// grant/ack handshake; y carries the active-low winner index while valid.
module prio_encoder_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic             clk,
  input  logic             reset,
  prio_encoder_arb_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic [W-1:0] ptr;
  logic [W-1:0] win_idx;
  logic [W-1:0] fixed_idx;
  logic [W-1:0] rr_idx;
  logic [W-1:0] rr_cand;
  logic [W-1:0] pick_idx;
  logic         any_pending;
  logic         ack_grant;

  assign any_pending = |pending;
  assign ack_grant   = (state == GRANT) && bus.ack;
  assign set_mask    = bus.en_in_n ? '0 : ~bus.v_n;

  // Only the acknowledged winner is retired; a same-cycle request re-sets it.
  always_comb begin
    clr_mask = '0;
    if (ack_grant) begin
      clr_mask[win_idx] = 1'b1;
    end
  end

  // Fixed priority: highest set index wins (later iterations overwrite).
  always_comb begin
    fixed_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        fixed_idx = W'(i);
      end
    end
  end

  // Round-robin: search ptr-1 downward with wrap; the nearest candidate
  // is visited last so it overwrites farther ones. Offset N wraps to ptr.
  always_comb begin
    rr_idx  = '0;
    rr_cand = '0;
    for (int off = N; off >= 1; off--) begin
      rr_cand = W'(ptr - W'(off));
      if (pending[rr_cand]) begin
        rr_idx = rr_cand;
      end
    end
  end

  assign pick_idx = bus.rr_mode ? rr_idx : fixed_idx;

  assign bus.gs     = ~(~bus.en_in_n &  any_pending);
  assign bus.en_out = ~(~bus.en_in_n & ~any_pending);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      ptr       <= '0;
      win_idx   <= '0;
      bus.valid <= 1'b0;
      bus.y     <= '1;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      case (state)
        IDLE: begin
          if (!bus.en_in_n && any_pending) begin
            win_idx   <= pick_idx;
            bus.y     <= ~pick_idx;
            bus.valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            ptr       <= win_idx;
            bus.valid <= 1'b0;
            bus.y     <= '1;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_arb.sv
// Scoreboard bench for prio_encoder_arb: a cycle-level reference model
// predicts grants, a negedge monitor checks every output.
module tb_prio_encoder_arb;
  localparam int unsigned N   = 8;
  localparam int unsigned W   = 3;
  localparam int unsigned N16 = 16;
  localparam int unsigned W16 = 4;

  logic clk = 1'b0;
  logic reset;
  logic reset16;
  always #5 clk = ~clk;

  prio_encoder_arb_if #(.N(N),   .W(W))   ifc ();
  prio_encoder_arb_if #(.N(N16), .W(W16)) ifc16 ();

  prio_encoder_arb #(.N(N),   .W(W))   dut   (.clk(clk), .reset(reset),   .bus(ifc));
  prio_encoder_arb #(.N(N16), .W(W16)) dut16 (.clk(clk), .reset(reset16), .bus(ifc16));

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];
  int obs[$];

  bit m_pend[N];
  int m_ptr;
  bit m_valid;
  int m_win;
  bit mon_en = 1'b0;
  bit prev_v = 1'b0;
  int e_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pend();
    foreach (m_pend[i]) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Winner by the arbitration rules: highest index, or nearest below ptr with wrap.
  function automatic int pick(input bit rr);
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (m_pend[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int i = (m_ptr - k + N) % N;
        if (m_pend[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit en_n, input logic [N-1:0] v,
                            input bit rr, input bit a);
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0; m_valid = 1'b0; m_win = 0;
      return;
    end
    if (!m_valid) begin
      if (!en_n && any_pend()) begin
        m_win = pick(rr);
        m_valid = 1'b1;
        sb.push_back(m_win);
      end
    end else if (a) begin
      m_pend[m_win] = 1'b0;
      m_ptr = m_win;
      m_valid = 1'b0;
    end
    if (!en_n) for (int i = 0; i < N; i++) if (v[i] === 1'b0) m_pend[i] = 1'b1;
  endtask

  task automatic cycle(input bit rst, input bit en_n, input logic [N-1:0] v,
                       input bit rr, input bit a);
    reset = rst; ifc.en_in_n = en_n; ifc.v_n = v; ifc.rr_mode = rr; ifc.ack = a;
    @(posedge clk);
    model_step(rst, en_n, v, rr, a);
    #1;
  endtask

  // Monitor: per-cycle output checks plus scoreboard pop on each new grant.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", 32'(ifc.valid), 32'(m_valid));
      if (!ifc.valid) check("y_idle", 32'(ifc.y), 32'(N - 1));
      check("gs", 32'(ifc.gs), 32'(!(!ifc.en_in_n && any_pend())));
      check("en_out", 32'(ifc.en_out), 32'(!(!ifc.en_in_n && !any_pend())));
      if (ifc.valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL grant_unexpected: got y=%0h expected no grant at %0t", ifc.y, $time);
        end else begin
          e_idx = sb.pop_front();
          check("grant_y", 32'(ifc.y), 32'(N - 1 - e_idx));
        end
        obs.push_back(int'(N - 1) - int'(ifc.y));
      end
      prev_v = ifc.valid;
    end
  end

  int rr_exp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int fx_exp[2] = '{7, 0};
  bit r_rst, r_en, r_rr, r_a;
  logic [N-1:0] r_v;

  initial begin
    reset16 = 1'b1; ifc16.en_in_n = 1'b1; ifc16.v_n = '1; ifc16.rr_mode = 1'b0; ifc16.ack = 1'b0;

    cycle(1, 1, '1, 0, 0);
    mon_en = 1'b1;
    cycle(1, 0, '1, 0, 0);
    check("rst_valid", 32'(ifc.valid), 0);
    check("rst_y", 32'(ifc.y), 7);
    check("rst_gs", 32'(ifc.gs), 1);
    check("rst_en_out", 32'(ifc.en_out), 0);

    // single request, two-cycle latency then ack
    cycle(0, 0, 8'hFE, 0, 0);
    cycle(0, 0, '1, 0, 0);
    check("single_valid", 32'(ifc.valid), 1);
    check("single_y", 32'(ifc.y), 7);
    check("single_gs", 32'(ifc.gs), 0);
    cycle(0, 0, '1, 0, 1);
    check("single_ack_valid", 32'(ifc.valid), 0);
    check("single_ack_en_out", 32'(ifc.en_out), 0);
    check("single_ack_gs", 32'(ifc.gs), 1);

    // disabled: requests ignored
    repeat (5) cycle(0, 1, 8'h00, 0, 0);
    check("dis_en_out", 32'(ifc.en_out), 1);
    check("dis_gs", 32'(ifc.gs), 1);
    repeat (2) cycle(0, 0, '1, 0, 0);
    check("dis_after_en_out", 32'(ifc.en_out), 0);
    check("dis_after_valid", 32'(ifc.valid), 0);

    // fixed priority order
    obs.delete();
    cycle(0, 0, 8'h7E, 0, 0);
    repeat (8) cycle(0, 0, '1, 0, m_valid);
    check("fixed_count", 32'(obs.size()), 2);
    for (int i = 0; i < 2; i++)
      check("fixed_order", (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(fx_exp[i]));
    check("fixed_end_valid", 32'(ifc.valid), 0);

    // round-robin with all requests held
    obs.delete();
    repeat (19) cycle(0, 0, 8'h00, 1, m_valid);
    check("rr_count", 32'(obs.size()), 9);
    for (int i = 0; i < 9; i++)
      check("rr_order", (i < obs.size()) ? 32'(obs[i]) : 32'hFFFF_FFFF, 32'(rr_exp[i]));

    // ack while idle is ignored
    cycle(1, 0, '1, 0, 0);
    repeat (3) cycle(0, 1, '1, 0, 1);
    check("idle_ack_valid", 32'(ifc.valid), 0);
    check("idle_ack_en_out", 32'(ifc.en_out), 1);

    // reset mid-grant beats ack and requests
    cycle(0, 0, 8'hEF, 0, 0);
    cycle(0, 0, '1, 0, 0);
    check("midrst_grant_y", 32'(ifc.y), 3);
    cycle(1, 0, 8'h00, 0, 1);
    check("midrst_valid", 32'(ifc.valid), 0);
    check("midrst_y", 32'(ifc.y), 7);
    check("midrst_en_out", 32'(ifc.en_out), 0);
    check("midrst_gs", 32'(ifc.gs), 1);

    // randomized traffic against the model
    r_rr = 1'b0;
    repeat (3000) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) r_v[i] = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 15) == 0) r_rr = ~r_rr;
      r_a = $urandom_range(0, 1) != 0;
      cycle(r_rst, r_en, r_v, r_rr, r_a);
    end
    repeat (2) cycle(0, 1, '1, r_rr, 1);

    // N=16 instance
    @(posedge clk); #1;
    reset16 = 1'b0; ifc16.en_in_n = 1'b0; ifc16.v_n = 16'hEFFF;
    @(posedge clk); #1;
    ifc16.v_n = '1;
    @(posedge clk); #1;
    check("n16_valid", 32'(ifc16.valid), 1);
    check("n16_y", 32'(ifc16.y), 32'h3);
    check("n16_gs", 32'(ifc16.gs), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
